// File: rtl/mux_bank_out_stream.sv
// N:1 bank-output selector for the NTT memory-bank read path.
// Each command is either a single beat or a strided burst with modulo wrap, streamed through a registered valid/ready output stage.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command; a pending beat may drain
// RUN   | issuing beats whenever the output slot is free; cmd_ready=0
module mux_bank_out_stream #(
    parameter int N_BANK  = 16,
    parameter int D_WIDTH = 64,
    parameter int SEL_W   = $clog2(N_BANK)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_BANK*D_WIDTH-1:0] Q_in,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_burst,
    input  logic [SEL_W-1:0]          cmd_sel,
    input  logic [SEL_W:0]            cmd_len,
    input  logic [SEL_W-1:0]          cmd_stride,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [D_WIDTH-1:0]        Q_out,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_last,
    output logic                      busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_BANK);
    localparam logic [SEL_W:0] ONE   = (SEL_W+1)'(1);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cur_sel, cur_sel_nxt;
    logic [SEL_W-1:0]   stride, stride_nxt;
    logic [SEL_W:0]     remaining, remaining_nxt;
    logic               out_valid_nxt;
    logic [D_WIDTH-1:0] q_out_nxt;
    logic [SEL_W-1:0]   out_sel_nxt;
    logic               out_last_nxt;

    logic               slot_free;
    logic [D_WIDTH-1:0] sel_word;
    logic [SEL_W:0]     sel_sum;
    logic [SEL_W:0]     sel_wrap;
    logic [SEL_W:0]     stride_ext;
    logic [SEL_W:0]     stride_red;
    logic [SEL_W:0]     len_in;

    // Indices at or above N_BANK (non-power-of-two banks) match no bank and read as zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_BANK; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                sel_word = Q_in[k*D_WIDTH +: D_WIDTH];
            end
        end
    end

    always_comb begin
        slot_free  = !out_valid || out_ready;
        sel_sum    = {1'b0, cur_sel} + {1'b0, stride};
        sel_wrap   = (sel_sum >= N_EXT) ? (sel_sum - N_EXT) : sel_sum;
        stride_ext = {1'b0, cmd_stride};
        stride_red = (stride_ext >= N_EXT) ? (stride_ext - N_EXT) : stride_ext;
        if (!cmd_burst || (cmd_len == '0)) begin
            len_in = ONE;
        end else if (cmd_len > N_EXT) begin
            len_in = N_EXT;
        end else begin
            len_in = cmd_len;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_sel_nxt   = cur_sel;
        stride_nxt    = stride;
        remaining_nxt = remaining;
        out_valid_nxt = out_valid;
        q_out_nxt     = Q_out;
        out_sel_nxt   = out_sel;
        out_last_nxt  = out_last;
        cmd_ready     = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                end
                if (cmd_valid) begin
                    cur_sel_nxt   = cmd_sel;
                    stride_nxt    = stride_red[SEL_W-1:0];
                    remaining_nxt = len_in;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (slot_free) begin
                    q_out_nxt     = sel_word;
                    out_sel_nxt   = cur_sel;
                    out_last_nxt  = (remaining == ONE);
                    out_valid_nxt = 1'b1;
                    cur_sel_nxt   = sel_wrap[SEL_W-1:0];
                    remaining_nxt = remaining - ONE;
                    if (remaining == ONE) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_sel   <= '0;
            stride    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            Q_out     <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_sel   <= cur_sel_nxt;
            stride    <= stride_nxt;
            remaining <= remaining_nxt;
            out_valid <= out_valid_nxt;
            Q_out     <= q_out_nxt;
            out_sel   <= out_sel_nxt;
            out_last  <= out_last_nxt;
        end
    end

    assign busy = (state == RUN) || out_valid;

endmodule
